grf_multiport: RTL and testbench

Parametrised general-purpose register file for the pipelined CPU's decode stage. Supports configurable data width, depth, and read/write port counts. Provides a hardwired zero register and same-cycle write-to-read bypass. An optional scoreboard tracks registers with outstanding producers and flags reads that must stall.

---
 rtl/grf_pkg.sv | 23 ++
 rtl/grf_scoreboard.sv | 72 +++++++
 rtl/grf_multiport.sv | 99 +++++++++
 tb/tb_grf_multiport.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/grf_pkg.sv
// Shared constants and helpers for the general-purpose register file.
// Holds default widths, the zero-register index and a popcount helper.
package grf_pkg;

  localparam int GRF_DATA_W   = 32;
  localparam int GRF_ADDR_W   = 5;
  localparam int GRF_ZERO_REG = 0;

  // popcount input width; covers ADDR_W up to 8
  localparam int GRF_POP_W    = 256;

  function automatic int unsigned popcount(
    input logic [GRF_POP_W-1:0] v
  );
    int unsigned c;
    c = 0;
    for (int i = 0; i < GRF_POP_W; i++) begin
      c = c + 32'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/grf_scoreboard.sv
// Pending-producer scoreboard: set on issue, clear on write, flush-all.
// Ports: clk, reset, iss_en/iss_addr, flush, wr_en/wr_addr, rd_addr,
// rd_hit (per-port bypass hit), rd_busy, pend_cnt.
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int ADDR_W = GRF_ADDR_W,
  parameter int N_RD   = 2,
  parameter int N_WR   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   iss_en,
  input  logic [ADDR_W-1:0]      iss_addr,
  input  logic                   flush,
  input  logic [N_WR-1:0]        wr_en,
  input  logic [N_WR*ADDR_W-1:0] wr_addr,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  input  logic [N_RD-1:0]        rd_hit,
  output logic [N_RD-1:0]        rd_busy,
  output logic [ADDR_W:0]        pend_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(GRF_ZERO_REG);

  // bit 0 is held at 0 so address 0 is never pending
  logic [DEPTH-1:0]     pend_q;
  logic [DEPTH-1:0]     pend_d;
  logic [GRF_POP_W-1:0] pop_in;

  always_comb begin
    pend_d = pend_q;
    if (flush) begin
      pend_d = '0;
    end else begin
      for (int k = 0; k < N_WR; k++) begin
        if (wr_en[k]) begin
          pend_d[wr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
        end
      end
    end
    // a new producer supersedes any clear or flush
    if (iss_en) begin
      pend_d[iss_addr] = 1'b1;
    end
    pend_d[ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int j = 0; j < N_RD; j++) begin
      rd_busy[j] = pend_q[rd_addr[j*ADDR_W +: ADDR_W]] && !rd_hit[j];
    end
  end

  always_comb begin
    pop_in = '0;
    pop_in[DEPTH-1:0] = pend_q;
  end

  assign pend_cnt = (ADDR_W+1)'(popcount(pop_in));

endmodule

// File: rtl/grf_multiport.sv
// Multi-port register file with zero register and write-to-read bypass.
// Ports: clk, reset, wr_en/wr_addr/wr_data, rd_addr/rd_data, iss_en,
// iss_addr, flush, rd_busy, pend_cnt. GRF_SCOREBOARD_EN adds scoreboard.
module grf_multiport
  import grf_pkg::*;
#(
  parameter int DATA_W = GRF_DATA_W,
  parameter int ADDR_W = GRF_ADDR_W,
  parameter int N_RD   = 2,
  parameter int N_WR   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_WR-1:0]        wr_en,
  input  logic [N_WR*ADDR_W-1:0] wr_addr,
  input  logic [N_WR*DATA_W-1:0] wr_data,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  output logic [N_RD*DATA_W-1:0] rd_data,
  input  logic                   iss_en,
  input  logic [ADDR_W-1:0]      iss_addr,
  input  logic                   flush,
  output logic [N_RD-1:0]        rd_busy,
  output logic [ADDR_W:0]        pend_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(GRF_ZERO_REG);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [N_RD-1:0]   rd_hit;

  // ascending port order lets the higher port win a collision
  always_comb begin
    regs_d = regs_q;
    for (int k = 0; k < N_WR; k++) begin
      if (wr_en[k] && wr_addr[k*ADDR_W +: ADDR_W] != ZERO) begin
        regs_d[wr_addr[k*ADDR_W +: ADDR_W]] = wr_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_hit  = '0;
    for (int j = 0; j < N_RD; j++) begin
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rv;
      ra = rd_addr[j*ADDR_W +: ADDR_W];
      rv = regs_q[ra];
      for (int k = 0; k < N_WR; k++) begin
        if (wr_en[k] && wr_addr[k*ADDR_W +: ADDR_W] == ra && ra != ZERO) begin
          rv        = wr_data[k*DATA_W +: DATA_W];
          rd_hit[j] = 1'b1;
        end
      end
      if (ra == ZERO) begin
        rv = '0;
      end
      rd_data[j*DATA_W +: DATA_W] = rv;
    end
  end

`ifdef GRF_SCOREBOARD_EN
  grf_scoreboard #(
    .ADDR_W (ADDR_W),
    .N_RD   (N_RD),
    .N_WR   (N_WR)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr),
    .rd_hit   (rd_hit),
    .rd_busy  (rd_busy),
    .pend_cnt (pend_cnt)
  );
`else
  logic sb_unused;
  assign sb_unused = ^{iss_en, iss_addr, flush, rd_hit};
  assign rd_busy   = '0;
  assign pend_cnt  = '0;
`endif

endmodule

// File: tb/tb_grf_multiport.sv
// Self-checking bench for grf_multiport (N_RD=2, N_WR=2, 32x32).
// Vector table plus a hand-written reset-mid-run sequence.
`timescale 1ns/1ps
module tb_grf_multiport;

`ifdef GRF_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        flush;
  logic [1:0]  rd_busy;
  logic [5:0]  pend_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  grf_multiport #(
    .DATA_W (32),
    .ADDR_W (5),
    .N_RD   (2),
    .N_WR   (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .rd_busy  (rd_busy),
    .pend_cnt (pend_cnt)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        ie;
    logic [4:0]  ia;
    logic        fl;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
    logic [5:0]  ec;
  } vec_t;

  vec_t tv [17];

  function automatic vec_t mk(
    input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
    input logic [4:0] wa1, input logic [31:0] wd1,
    input logic [4:0] ra0, input logic [4:0] ra1,
    input logic ie, input logic [4:0] ia, input logic fl,
    input logic [31:0] e0, input logic [31:0] e1,
    input logic [1:0] eb, input logic [5:0] ec
  );
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ra0 = ra0; v.ra1 = ra1; v.ie = ie; v.ia = ia; v.fl = fl;
    v.e0 = e0; v.e1 = e1; v.eb = eb; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    wr_en    = v.we;
    wr_addr  = {v.wa1, v.wa0};
    wr_data  = {v.wd1, v.wd0};
    rd_addr  = {v.ra1, v.ra0};
    iss_en   = v.ie;
    iss_addr = v.ia;
    flush    = v.fl;
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  function automatic logic [31:0] rv(input int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  initial begin
    //              we    wa0 wd0           wa1 wd1           ra0 ra1 ie ia fl e0            e1            eb     ec
    tv[0]  = mk(2'b00, 0, 0,            0, 0,            0,  5, 0, 0, 0, 0,            0,            2'b00, 0);
    tv[1]  = mk(2'b01, 5, 32'hDEADBEEF, 0, 0,            5,  0, 0, 0, 0, 32'hDEADBEEF, 0,            2'b00, 0);
    tv[2]  = mk(2'b00, 0, 0,            0, 0,            5,  7, 0, 0, 0, 32'hDEADBEEF, 0,            2'b00, 0);
    tv[3]  = mk(2'b11, 7, 32'h11,       7, 32'h22,       7,  5, 0, 0, 0, 32'h22,       32'hDEADBEEF, 2'b00, 0);
    tv[4]  = mk(2'b00, 0, 0,            0, 0,            7,  0, 0, 0, 0, 32'h22,       0,            2'b00, 0);
    tv[5]  = mk(2'b11, 0, 32'hFFFFFFFF, 0, 32'h12345678, 0,  0, 1, 0, 0, 0,            0,            2'b00, 0);
    tv[6]  = mk(2'b00, 0, 0,            0, 0,            0,  3, 1, 3, 0, 0,            0,            2'b00, 0);
    tv[7]  = mk(2'b00, 0, 0,            0, 0,            3,  5, 0, 0, 0, 0,            32'hDEADBEEF, 2'b01, 1);
    tv[8]  = mk(2'b10, 0, 0,            3, 32'h33,       3,  3, 0, 0, 0, 32'h33,       32'h33,       2'b00, 1);
    tv[9]  = mk(2'b00, 0, 0,            0, 0,            3,  0, 0, 0, 0, 32'h33,       0,            2'b00, 0);
    tv[10] = mk(2'b01, 4, 32'h44,       0, 0,            4,  4, 1, 4, 0, 32'h44,       32'h44,       2'b00, 0);
    tv[11] = mk(2'b00, 0, 0,            0, 0,            4,  5, 0, 0, 0, 32'h44,       32'hDEADBEEF, 2'b01, 1);
    tv[12] = mk(2'b00, 0, 0,            0, 0,            6,  0, 1, 6, 0, 0,            0,            2'b00, 1);
    tv[13] = mk(2'b00, 0, 0,            0, 0,            4,  6, 1, 9, 1, 32'h44,       0,            2'b11, 2);
    tv[14] = mk(2'b00, 0, 0,            0, 0,            9,  4, 0, 0, 0, 0,            32'h44,       2'b01, 1);
    tv[15] = mk(2'b11, 2, 32'h2,        9, 32'h99,       9,  2, 0, 0, 0, 32'h99,       32'h2,        2'b00, 1);
    tv[16] = mk(2'b00, 0, 0,            0, 0,            9,  2, 0, 0, 0, 32'h99,       32'h2,        2'b00, 0);

    reset = 1'b1;
    idle();
    rd_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(tv[i]);
      #1;
      chk($sformatf("v%0d rd0", i), rd_data[31:0], tv[i].e0);
      chk($sformatf("v%0d rd1", i), rd_data[63:32], tv[i].e1);
      chk($sformatf("v%0d busy", i), 32'(rd_busy), SB ? 32'(tv[i].eb) : 32'd0);
      chk($sformatf("v%0d cnt", i), 32'(pend_cnt), SB ? 32'(tv[i].ec) : 32'd0);
    end

    // fill regs 1..31 using both write ports
    for (int i = 1; i <= 31; i += 2) begin
      @(negedge clk);
      idle();
      wr_en[0]       = 1'b1;
      wr_addr[4:0]   = 5'(i);
      wr_data[31:0]  = rv(i);
      if (i + 1 <= 31) begin
        wr_en[1]       = 1'b1;
        wr_addr[9:5]   = 5'(i + 1);
        wr_data[63:32] = rv(i + 1);
      end
    end
    for (int i = 10; i <= 12; i++) begin
      @(negedge clk);
      idle();
      iss_en   = 1'b1;
      iss_addr = 5'(i);
    end
    @(negedge clk);
    idle();
    rd_addr = {5'd1, 5'd31};
    #1;
    chk("pre rst r31", rd_data[31:0], rv(31));
    chk("pre rst r1", rd_data[63:32], rv(1));
    chk("pre rst cnt", 32'(pend_cnt), SB ? 32'd3 : 32'd0);

    // reset with a write and an issue in flight on the same edge
    @(negedge clk);
    reset    = 1'b1;
    wr_en    = 2'b01;
    wr_addr  = {5'd0, 5'd5};
    wr_data  = {32'd0, 32'h55};
    iss_en   = 1'b1;
    iss_addr = 5'd13;
    @(negedge clk);
    reset = 1'b0;
    idle();
    #1;
    chk("post rst cnt", 32'(pend_cnt), 32'd0);
    for (int i = 1; i <= 31; i++) begin
      if (i > 1) @(negedge clk);
      rd_addr = {5'(32 - i), 5'(i)};
      #1;
      chk($sformatf("post rst r%0d", i), rd_data[31:0], 32'd0);
      chk($sformatf("post rst r%0d", 32 - i), rd_data[63:32], 32'd0);
      chk($sformatf("post rst busy a%0d", i), 32'(rd_busy), 32'd0);
    end
    chk("post rst cnt end", 32'(pend_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
